avmm_burst_mem_slave: RTL
=========================

// Module: avmm_burst_mem_slave
// PURPOSE
//  Avalon-MM burst-capable responder (slave) backed by an internal word array.
//  Sits on the avs_* side of mem_fsm in place of the real local-memory controller,
//  so directed and address tests can run without DDR.
//  Accepts single and burst reads/writes, returns read data at fixed latency
//  and issues write responses.
// PARAMETERS
//  ADDR_WIDTH     26  word address width of avs_address
//  DATA_WIDTH     64  data word width
//  DEPTH_LOG2     6   array depth = 2**DEPTH_LOG2 words; higher addresses are out of range
//  BURST_WIDTH    12  avs_burstcount width
//  READ_LATENCY   2   cycles from read accept to first readdatavalid; legal range 1..8
// PORTS
//  pClk                    in   1            clock
//  pck_cp2af_softReset     in   1            synchronous active-high reset
//  avs_address             in   ADDR_WIDTH   word address; sampled on the first beat only
//  avs_write               in   1            write request / write beat
//  avs_read                in   1            read request
//  avs_writedata           in   DATA_WIDTH   write data
//  avs_byteenable          in   64           bit i enables byte i; bits >= DATA_WIDTH/8 ignored
//  avs_burstcount          in   BURST_WIDTH  beats; 0 treated as 1
//  avs_waitrequest         out  1            command/beat not accepted this cycle
//  avs_readdata            out  DATA_WIDTH   read data
//  avs_readdatavalid       out  1            readdata valid, one beat per cycle
//  avs_response            out  2            00 OKAY, 10 SLVERR; valid with readdatavalid/writeresponsevalid
//  avs_writeresponsevalid  out  1            one-cycle pulse per completed write burst
// BEHAVIOUR
//  Reset values:
//   - waitrequest=1 during reset; 0 in the cycle after reset deasserts.
//   - readdatavalid=0, writeresponsevalid=0, response=00, readdata=0.
//   - Array contents are not reset.
//  Accept:
//   - A beat or command is taken when (write|read) & ~waitrequest.
//  FSM IDLE -> WR_BURST | RD_BURST; WR_BURST -> WR_RESP -> IDLE; RD_BURST -> IDLE.
//  IDLE:
//   - waitrequest=0.
//   - write&read together: write accepted, read ignored and not queued.
//   - Write accept: latch base = address and N = burstcount (0 -> 1), beat index = 0,
//     store beat 0, then go to WR_BURST (N = 1 goes directly to WR_RESP).
//   - Read accept: latch base and N, go to RD_BURST.
//  WR_BURST:
//   - waitrequest=0.
//   - Each accepted write stores beat i at base+i. Gaps with write=0 are legal.
//   - avs_read is ignored in this state.
//   - Go to WR_RESP after beat N-1 is stored.
//  WR_RESP:
//   - waitrequest=1.
//   - writeresponsevalid=1 for exactly one cycle.
//   - response=10 if any beat of the burst was out of range, else 00. Then IDLE.
//  RD_BURST:
//   - waitrequest=1.
//   - One beat per cycle enters a READ_LATENCY-deep valid/data/resp pipe; no read backpressure.
//   - Accept at cycle T -> beats at T+READ_LATENCY .. T+READ_LATENCY+N-1,
//     readdatavalid continuous across them.
//   - Return to IDLE only after the last beat leaves the pipe.
//   - The next command can be accepted in the cycle after the last readdatavalid.
//  Address arithmetic:
//   - Beat address = base+i, computed in ADDR_WIDTH bits; wraps at 2**ADDR_WIDTH.
//   - A beat is out of range if any address bit >= DEPTH_LOG2 is set.
//   - Out-of-range write beats are dropped with no array change.
//   - Out-of-range read beats return data 0 with response 10.
//   - Range is checked per beat, so a burst crossing the top of the array errors
//     only on the beats past the top.
//  Byte enables:
//   - Write: only enabled bytes are updated.
//   - Read: always the full word.
//  Reset mid-burst: abort the burst and flush the pipe; no further readdatavalid
//  or writeresponsevalid for that burst.
// CONFIGURATION
//  AVMM_WAITREQ_INJECT_EN defined:
//   - A 16-bit LFSR (seed 16'hACE1, reloaded on reset) forces waitrequest=1
//     in IDLE/WR_BURST on cycles where lfsr[1:0]==2'b11.
//   - Stalls never affect the read pipe and never drop data.
//  Undefined: waitrequest is exactly as listed in BEHAVIOUR.
// TESTING
//  1. Write addr 5, data 64'hDEAD_BEEF, be all-ones, N=1 -> writeresponsevalid
//     2 cycles after accept, resp 00. Read addr 5 -> readdatavalid at T+2
//     with 64'hDEAD_BEEF.
//  2. Write burst N=4 at addr 60, data 1..4, with a 1-cycle write=0 gap ->
//     4 beats stored, 1 response. Read N=4 at 60 -> 1,2,3,4 on 4 consecutive cycles.
//  3. Read N=4 at addr 62 -> data mem[62],mem[63],0,0; resp 00,00,10,10.
//     Write to addr 64 -> resp 10, mem[0] unchanged.
//  4. Write be=8'h0F, data all-ones over 64'h0 -> readback 64'h0000_0000_FFFF_FFFF.
//  5. Assert write and read together in IDLE -> only the write completes;
//     no readdatavalid. Reset during the 2nd beat of an N=8 read ->
//     readdatavalid=0 from the next cycle, waitrequest=0 after reset.
//  6. With AVMM_WAITREQ_INJECT_EN: a 64-word write/read sweep matches mem_fsm
//     addr_test_done=1 with zero data mismatches.

Source files
------------

// File: rtl/avmm_burst_mem_slave.sv
// Avalon-MM burst responder backed by an internal word array, with fixed read latency and write responses.
// Optional build macro AVMM_WAITREQ_INJECT_EN adds LFSR-driven waitrequest stalls on the command side.
module avmm_burst_mem_slave #(
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH_LOG2   = 6,
  parameter int BURST_WIDTH  = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                   pClk,
  input  logic                   pck_cp2af_softReset,
  input  logic [ADDR_WIDTH-1:0]  avs_address,
  input  logic                   avs_write,
  input  logic                   avs_read,
  input  logic [DATA_WIDTH-1:0]  avs_writedata,
  input  logic [63:0]            avs_byteenable,
  input  logic [BURST_WIDTH-1:0] avs_burstcount,
  output logic                   avs_waitrequest,
  output logic [DATA_WIDTH-1:0]  avs_readdata,
  output logic                   avs_readdatavalid,
  output logic [1:0]             avs_response,
  output logic                   avs_writeresponsevalid
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int DR_W  = BURST_WIDTH + 4;

  typedef enum logic [1:0] {S_IDLE, S_WR_BURST, S_WR_RESP, S_RD_BURST} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   base_q, beat_addr;
  logic [BURST_WIDTH-1:0]  n_q, n_in, idx_q;
  logic [DR_W-1:0]         drain_q;
  logic                    err_q, wrv_q;
  logic [1:0]              wresp_q;
  logic                    stall, cmd_state, wr_acc, rd_acc, rd_issue, beat_ok;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [READ_LATENCY-1:0] vld_p;
  logic [DATA_WIDTH-1:0]   data_p [READ_LATENCY];
  logic [1:0]              resp_p [READ_LATENCY];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> DEPTH_LOG2) == '0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] byte_merge(input logic [DATA_WIDTH-1:0] old_w,
                                                       input logic [DATA_WIDTH-1:0] new_w,
                                                       input logic [NB-1:0]         be);
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < NB; b++)
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  generate
    if (NB < 64) begin : g_be_unused
      logic unused_be;
      assign unused_be = ^avs_byteenable[63:NB];
    end
  endgenerate

`ifdef AVMM_WAITREQ_INJECT_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) lfsr_q <= 16'hACE1;
    else                     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall = (lfsr_q[1:0] == 2'b11);
`else
  assign stall = 1'b0;
`endif

  // Command side: acceptance, beat address and range check
  always_comb begin
    cmd_state       = (state == S_IDLE) || (state == S_WR_BURST);
    avs_waitrequest = pck_cp2af_softReset | ~cmd_state | stall;
    wr_acc          = avs_write & ~avs_waitrequest;
    rd_acc          = avs_read & ~avs_write & ~avs_waitrequest & (state == S_IDLE);
    n_in            = (avs_burstcount == '0) ? BURST_WIDTH'(1) : avs_burstcount;
    beat_addr       = (state == S_IDLE) ? avs_address : base_q + ADDR_WIDTH'(idx_q);
    beat_ok         = in_range(beat_addr);
    rd_issue        = rd_acc | ((state == S_RD_BURST) && (idx_q < n_q));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (wr_acc)      state_nxt = (n_in == BURST_WIDTH'(1)) ? S_WR_RESP : S_WR_BURST;
        else if (rd_acc) state_nxt = S_RD_BURST;
      end
      S_WR_BURST: if (wr_acc && (idx_q == n_q - BURST_WIDTH'(1))) state_nxt = S_WR_RESP;
      S_WR_RESP:  state_nxt = S_IDLE;
      S_RD_BURST: if (drain_q == '0) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      state   <= S_IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
      wrv_q   <= 1'b0;
      wresp_q <= 2'b00;
      vld_p   <= '0;
    end else begin
      state <= state_nxt;
      wrv_q <= (state == S_WR_RESP);
      if (state == S_WR_RESP) wresp_q <= err_q ? 2'b10 : 2'b00;
      vld_p[0] <= rd_issue;
      for (int s = 1; s < READ_LATENCY; s++) vld_p[s] <= vld_p[s-1];
      if (wr_acc) begin
        if (state == S_IDLE) begin
          idx_q <= BURST_WIDTH'(1);
          err_q <= ~beat_ok;
        end else begin
          idx_q <= idx_q + BURST_WIDTH'(1);
          err_q <= err_q | ~beat_ok;
        end
      end else if (rd_acc) begin
        idx_q   <= BURST_WIDTH'(1);
        drain_q <= DR_W'(n_in) + DR_W'(READ_LATENCY) - DR_W'(2);
      end else if (state == S_RD_BURST) begin
        if (rd_issue) idx_q <= idx_q + BURST_WIDTH'(1);
        drain_q <= drain_q - DR_W'(1);
      end
    end
  end

  // Datapath: burst base/length, array writes and the read pipe (p0 = issue stage)
  always_ff @(posedge pClk) begin
    if ((state == S_IDLE) && (wr_acc || rd_acc)) begin
      base_q <= avs_address;
      n_q    <= n_in;
    end
    if (wr_acc && beat_ok)
      mem[beat_addr[DEPTH_LOG2-1:0]] <= byte_merge(mem[beat_addr[DEPTH_LOG2-1:0]],
                                                   avs_writedata, avs_byteenable[NB-1:0]);
    data_p[0] <= beat_ok ? mem[beat_addr[DEPTH_LOG2-1:0]] : '0;
    resp_p[0] <= beat_ok ? 2'b00 : 2'b10;
    for (int s = 1; s < READ_LATENCY; s++) begin
      data_p[s] <= data_p[s-1];
      resp_p[s] <= resp_p[s-1];
    end
  end

  // Output stage: response shared between read beats and write completions
  always_comb begin
    avs_readdatavalid      = vld_p[READ_LATENCY-1];
    avs_readdata           = avs_readdatavalid ? data_p[READ_LATENCY-1] : '0;
    avs_writeresponsevalid = wrv_q;
    avs_response           = avs_readdatavalid ? resp_p[READ_LATENCY-1] :
                             (wrv_q ? wresp_q : 2'b00);
  end

endmodule
